// File: rtl/mig_multiport_bridge.sv
// mig_multiport_bridge: round-robin bridge from NUM_PORTS cache line requesters onto one DDR2 MIG user interface.
// Optional MIG_BYTE_MASK_EN adds per-port byte enables driving app_wdf_mask_data.
module mig_multiport_bridge #(
   parameter int NUM_PORTS        = 2,
   parameter int APPDATA_WIDTH    = 128,
   parameter int LINE_BEATS       = 2,
   parameter int INPUT_ADDR_WIDTH = 31
) (
   input  logic                                             clk,
   input  logic                                             rst,
   input  logic                                             phy_init_done,
   input  logic [NUM_PORTS-1:0]                             req_valid,
   input  logic [NUM_PORTS-1:0]                             req_we,
   input  logic [NUM_PORTS*INPUT_ADDR_WIDTH-1:0]            req_addr,
   input  logic [NUM_PORTS*LINE_BEATS*APPDATA_WIDTH-1:0]    req_wdata,
`ifdef MIG_BYTE_MASK_EN
   input  logic [NUM_PORTS*LINE_BEATS*APPDATA_WIDTH/8-1:0]  req_be,
`endif
   output logic [NUM_PORTS-1:0]                             req_ready,
   output logic [NUM_PORTS-1:0]                             rsp_valid,
   output logic [LINE_BEATS*APPDATA_WIDTH-1:0]              rsp_rdata,
   output logic                                             err_spurious,
   input  logic                                             app_af_afull,
   input  logic                                             app_wdf_afull,
   input  logic                                             rd_data_valid,
   input  logic [APPDATA_WIDTH-1:0]                         rd_data_fifo_out,
   output logic                                             app_af_wren,
   output logic [INPUT_ADDR_WIDTH-1:0]                      app_af_addr,
   output logic [2:0]                                       app_af_cmd,
   output logic                                             app_wdf_wren,
   output logic [APPDATA_WIDTH-1:0]                         app_wdf_data,
   output logic [APPDATA_WIDTH/8-1:0]                       app_wdf_mask_data
);
   localparam int LW = LINE_BEATS*APPDATA_WIDTH;
   localparam int BW = APPDATA_WIDTH/8;
   localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
   localparam int CW = $clog2(LINE_BEATS);
   localparam int AL = $clog2(2*LINE_BEATS);

   typedef enum logic [2:0] {IDLE, WR_BEAT, RD_CMD, RD_WAIT, DONE} state_t;
   state_t state, state_d;

   logic [PW-1:0]               rr, owner, gnt_idx, cand;
   logic                        gnt, beat_go, last_beat;
   logic [CW-1:0]               cnt;
   logic [INPUT_ADDR_WIDTH-1:0] addr_q;
   logic [LW-1:0]               line_q, rbuf, rbuf_d;
`ifdef MIG_BYTE_MASK_EN
   logic [LINE_BEATS*BW-1:0]    be_q;
`endif

   // Scan from the highest offset down so the port closest to rr wins.
   always_comb begin
      gnt = 1'b0;
      gnt_idx = '0;
      cand = '0;
      for (int i = NUM_PORTS-1; i >= 0; i--) begin
         cand = PW'((int'(rr) + i) % NUM_PORTS);
         if (req_valid[cand]) begin
            gnt = 1'b1;
            gnt_idx = cand;
         end
      end
      gnt = gnt & phy_init_done & ~rst & (state == IDLE);
   end

   assign last_beat = cnt == CW'(LINE_BEATS-1);
   assign beat_go   = state == WR_BEAT && !app_wdf_afull && (cnt != '0 || !app_af_afull);

   always_comb begin
      rbuf_d = rbuf;
      rbuf_d[cnt*APPDATA_WIDTH +: APPDATA_WIDTH] = rd_data_fifo_out;
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    state_d = gnt ? (req_we[gnt_idx] ? WR_BEAT : RD_CMD) : IDLE;
         WR_BEAT: state_d = beat_go && last_beat ? DONE : WR_BEAT;
         RD_CMD:  state_d = app_af_afull ? RD_CMD : RD_WAIT;
         RD_WAIT: state_d = rd_data_valid && last_beat ? DONE : RD_WAIT;
         default: state_d = IDLE;
      endcase
   end

   assign req_ready    = gnt ? NUM_PORTS'(1'b1) << gnt_idx : '0;
   assign rsp_valid    = state == DONE ? NUM_PORTS'(1'b1) << owner : '0;
   assign app_af_wren  = (beat_go && cnt == '0) || (state == RD_CMD && !app_af_afull);
   assign app_af_cmd   = {2'b00, state == RD_CMD};
   assign app_af_addr  = addr_q & ({INPUT_ADDR_WIDTH{1'b1}} << AL);
   assign app_wdf_wren = beat_go;
   assign app_wdf_data = line_q[cnt*APPDATA_WIDTH +: APPDATA_WIDTH];
`ifdef MIG_BYTE_MASK_EN
   assign app_wdf_mask_data = beat_go ? ~be_q[cnt*BW +: BW] : '0;
`else
   assign app_wdf_mask_data = '0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         rr           <= '0;
         owner        <= '0;
         cnt          <= '0;
         addr_q       <= '0;
         line_q       <= '0;
         rbuf         <= '0;
         rsp_rdata    <= '0;
         err_spurious <= 1'b0;
`ifdef MIG_BYTE_MASK_EN
         be_q         <= '0;
`endif
      end else begin
         state <= state_d;
         if (rd_data_valid && state != RD_WAIT) err_spurious <= 1'b1;
         if (gnt) begin
            rr     <= PW'((int'(gnt_idx) + 1) % NUM_PORTS);
            owner  <= gnt_idx;
            cnt    <= '0;
            addr_q <= req_addr[gnt_idx*INPUT_ADDR_WIDTH +: INPUT_ADDR_WIDTH];
            line_q <= req_wdata[gnt_idx*LW +: LW];
`ifdef MIG_BYTE_MASK_EN
            be_q   <= req_be[gnt_idx*LINE_BEATS*BW +: LINE_BEATS*BW];
`endif
         end
         if (beat_go) cnt <= last_beat ? '0 : cnt + 1'b1;
         if (state == RD_WAIT && rd_data_valid) begin
            rbuf <= rbuf_d;
            cnt  <= last_beat ? '0 : cnt + 1'b1;
            if (last_beat) rsp_rdata <= rbuf_d;
         end
      end
   end
endmodule
